inst_fetch_req: RTL and testbench
=================================

Name: inst_fetch_req

Overview:
- Pre-IF/IF fetch front end inside cpu_core, directly upstream of the AXI bridge on the instruction sram-like port.
- Owns the fetch PC and issues one instruction read at a time (req / addr_ok / data_ok).
- Buffers the returned instruction until the decode stage accepts it.
- Handles branch/exception redirects, including cancelling an in-flight read whose data must be discarded.

Parameters:
- RESET_PC, 32'h1C000000, first fetch address after reset.

Ports:
- clk  input  1  core clock (aclk).
- resetn  input  1  synchronous active-low reset.
- redirect_valid  input  1  one-cycle pulse: branch taken or exception/ertn flush.
- redirect_pc  input  32  target fetch address, sampled when redirect_valid=1.
- ds_allowin  input  1  decode stage can accept an instruction this cycle.
- fs_to_ds_valid  output  1  buffered instruction is valid.
- fs_to_ds_pc  output  32  PC of the buffered instruction.
- fs_to_ds_inst  output  32  buffered instruction word.
- inst_sram_req  output  1  read request.
- inst_sram_wr  output  1  constant 0.
- inst_sram_size  output  2  constant 2'b10 (4 bytes).
- inst_sram_wstrb  output  4  constant 4'b0000.
- inst_sram_addr  output  32  fetch address.
- inst_sram_wdata  output  32  constant 0.
- inst_sram_addr_ok  input  1  request accepted in this cycle (req & addr_ok).
- inst_sram_data_ok  input  1  read data returned in this cycle.
- inst_sram_rdata  input  32  read data, valid with data_ok.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-low, on resetn.
- Reset values:
  - state=RST, cancel=0, fetch_pc=RESET_PC.
  - inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_pc=0, fs_to_ds_inst=0.
- State RST: unconditionally go to REQ on the next cycle. The first request appears on the second cycle with resetn=1.
- State REQ:
  - inst_sram_req=1, inst_sram_addr=fetch_pc.
  - addr_ok=1 -> WAIT.
  - redirect without addr_ok -> fetch_pc<=redirect_pc and stay in REQ. The address may change because nothing has been accepted yet.
  - redirect with addr_ok in the same cycle -> WAIT with cancel<=1 and fetch_pc<=redirect_pc.
- State WAIT:
  - inst_sram_req=0. At most one read is outstanding.
  - data_ok with cancel=1 -> discard data, cancel<=0, go to REQ at fetch_pc.
  - data_ok with cancel=0 and no redirect -> buffer rdata and the PC of the accepted request, fs_to_ds_valid<=1, go to HOLD.
  - redirect without data_ok -> cancel<=1, fetch_pc<=redirect_pc.
  - redirect with data_ok in the same cycle -> discard data, cancel<=0, fetch_pc<=redirect_pc, go to REQ.
  - A repeat redirect while cancel=1 only updates fetch_pc (last one wins).
- State HOLD:
  - fs_to_ds_valid=1; pc and inst stay stable until transferred.
  - Transfer = fs_to_ds_valid & ds_allowin. On transfer: fs_to_ds_valid<=0, fetch_pc<=buffered_pc+4, go to REQ.
  - redirect (with or without ds_allowin) -> fs_to_ds_valid<=0, fetch_pc<=redirect_pc, go to REQ. No transfer occurs that cycle; redirect wins.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFFFFFC wraps to 0. No alignment check; the low 2 bits pass through as given.
- Latency: with a bridge that returns addr_ok and data_ok in the same cycle, one instruction is produced every 3 cycles (REQ, WAIT, HOLD with ds_allowin=1).
- Spurious inputs:
  - data_ok in REQ, HOLD or RST is ignored.
  - addr_ok while req=0 is ignored.
- Reset mid-operation: returns to RST, clearing cancel and the buffer. The bridge is reset in the same cycle, so no stale data_ok is expected.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, release; bridge gives addr_ok=1 and data_ok one cycle later with rdata=32'h02800C21, ds_allowin=1.
  -> req=1 with addr=1C000000 on the 2nd cycle after release.
  -> fs_to_ds_valid=1, pc=1C000000, inst=02800C21.
  -> next req addr=1C000004.
- Backpressure: ds_allowin=0 for 5 cycles while in HOLD.
  -> fs_to_ds_valid, pc and inst stay stable and req=0 throughout.
  -> on ds_allowin=1, the next cycle issues addr=pc+4.
- Addr wait: addr_ok=0 for 4 cycles, redirect to 1C000100 in cycle 2.
  -> req stays high.
  -> addr switches to 1C000100 the next cycle and is accepted when addr_ok rises.
- Cancel: redirect_pc=1C000200 while in WAIT; data_ok arrives 3 cycles later with rdata=DEADBEEF.
  -> data is not presented (fs_to_ds_valid stays 0).
  -> next req addr=1C000200.
- Simultaneous events:
  - redirect in the same cycle as a non-cancelled data_ok -> discard, next req addr=redirect_pc.
  - redirect in the same cycle as addr_ok -> the following data_ok is discarded.
- Wrap and reset mid-operation:
  - fetch at FFFFFFFC, then transfer -> next addr=00000000.
  - assert resetn=0 during WAIT -> all outputs are at reset values next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_req.sv
// ============================================================================
// inst_fetch_req
// ----------------------------------------------------------------------------
// Pre-IF / IF fetch front end of the CPU core. It sits directly upstream of
// the AXI bridge on the instruction sram-like port.
//
// The block owns the fetch PC and keeps at most one instruction read
// outstanding at any time. A returned instruction is buffered until the
// decode stage accepts it. Branch and exception redirects replace the fetch
// PC. If a read is already in flight when a redirect arrives, that read is
// marked cancelled, and its data is dropped when it returns.
//
// Parameters:
//   RESET_PC           first fetch address after reset
//
// Ports:
//   clk                core clock
//   resetn             synchronous active-low reset
//   redirect_valid     one-cycle redirect pulse (taken branch / flush)
//   redirect_pc        redirect target, sampled with redirect_valid
//   ds_allowin         decode stage can accept an instruction this cycle
//   fs_to_ds_valid     buffered instruction is valid
//   fs_to_ds_pc        PC of the buffered instruction
//   fs_to_ds_inst      buffered instruction word
//   inst_sram_req      read request
//   inst_sram_wr       always 0 (fetch never writes)
//   inst_sram_size     always 2'b10 (4 bytes)
//   inst_sram_wstrb    always 4'b0000
//   inst_sram_addr     fetch address
//   inst_sram_wdata    always 0
//   inst_sram_addr_ok  request accepted this cycle (together with req)
//   inst_sram_data_ok  read data returned this cycle
//   inst_sram_rdata    read data, valid with data_ok
// ============================================================================
module inst_fetch_req #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  // --------------------------------------------------------------------------
  // State encoding
  //   ST_RST  : one idle cycle after reset before the first request
  //   ST_REQ  : request asserted, waiting for the bridge to accept it
  //   ST_WAIT : request accepted, waiting for the read data
  //   ST_HOLD : instruction buffered, waiting for decode to take it
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state;

  // r_cancel marks the outstanding read as stale. It is set by a redirect
  // that arrives after the address was accepted, and it is cleared when the
  // stale data comes back.
  logic        r_cancel;

  // r_fetch_pc is the address of the next request. While a read that is not
  // cancelled is outstanding, r_fetch_pc still holds the address of that read.
  // This is because any event that changes the PC in WAIT also cancels the
  // read. For that reason, the buffered PC is taken directly from r_fetch_pc
  // and no separate copy of the accepted address is kept.
  logic [31:0] r_fetch_pc;

  // Registered outputs.
  logic        r_req;
  logic        r_ds_valid;
  logic [31:0] r_ds_pc;
  logic [31:0] r_ds_inst;

  // Decoded events.
  logic        w_addr_hs;
  logic        w_transfer;
  logic        w_data_kill;
  logic [31:0] w_seq_pc;

  // --------------------------------------------------------------------------
  // Handshake decode.
  // An addr_ok seen while req is low has no meaning, so the request is
  // qualified with the registered req.
  // Returned data is dropped when the read was already cancelled, or when a
  // redirect arrives in the same cycle as the data.
  // The sequential PC uses plain 32-bit modulo arithmetic. FFFFFFFC wraps to
  // 0, and the low two bits pass through unchanged.
  // --------------------------------------------------------------------------
  assign w_addr_hs   = r_req & inst_sram_addr_ok;
  assign w_transfer  = r_ds_valid & ds_allowin;
  assign w_data_kill = r_cancel | redirect_valid;
  assign w_seq_pc    = r_ds_pc + 32'd4;

  // --------------------------------------------------------------------------
  // Main fetch FSM. The state, the cancel flag, the fetch PC and all outputs
  // are updated here.
  // A data_ok that arrives outside ST_WAIT is ignored.
  // In ST_HOLD, a redirect takes priority over a transfer. The buffered
  // instruction belongs to the path that is being flushed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_RST;
      r_cancel   <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_ds_valid <= 1'b0;
      r_ds_pc    <= 32'd0;
      r_ds_inst  <= 32'd0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_REQ;
          r_req   <= 1'b1;
        end

        ST_REQ: begin
          if (w_addr_hs) begin
            r_state  <= ST_WAIT;
            r_req    <= 1'b0;
            // The read that was just accepted targets the old path.
            r_cancel <= redirect_valid;
          end
          // Before acceptance, the address can still change freely.
          if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
          end
        end

        ST_WAIT: begin
          if (inst_sram_data_ok) begin
            if (w_data_kill) begin
              r_cancel <= 1'b0;
              r_state  <= ST_REQ;
              r_req    <= 1'b1;
            end else begin
              r_ds_valid <= 1'b1;
              r_ds_pc    <= r_fetch_pc;
              r_ds_inst  <= inst_sram_rdata;
              r_state    <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            r_cancel <= 1'b1;
          end
          // If more than one redirect arrives, the last one wins.
          if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
          end
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            r_ds_valid <= 1'b0;
            r_fetch_pc <= redirect_pc;
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
          end else if (w_transfer) begin
            r_ds_valid <= 1'b0;
            r_fetch_pc <= w_seq_pc;
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_RST;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive.
  // The fetch path never writes, so the write-side fields are tied off.
  // --------------------------------------------------------------------------
  assign inst_sram_req   = r_req;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'd0;

  assign fs_to_ds_valid  = r_ds_valid;
  assign fs_to_ds_pc     = r_ds_pc;
  assign fs_to_ds_inst   = r_ds_inst;

endmodule

// File: tb/tb_inst_fetch_req.sv
// ============================================================================
// tb_inst_fetch_req
// ----------------------------------------------------------------------------
// Testbench for inst_fetch_req.
//
// The bench plays two roles:
//   - the instruction bridge, which drives addr_ok, data_ok and rdata;
//   - the decode stage, which drives ds_allowin.
//
// The reference model tracks the fetch unit only in terms of occupancy:
//   - the next PC to fetch;
//   - the read in flight, if any, and whether it has been killed;
//   - the buffered instruction.
//
// Each cycle, the stimulus task records the expected visible state and
// pushes the expected request and transfer events into queues. A separate
// monitor pops these entries and compares them with the DUT.
// ============================================================================
module tb_inst_fetch_req;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        ds_allowin = 1'b0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  int xferSeen = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          zero;
  } cyc_t;

  // Reference model state.
  bit          mRstPending = 1'b1;
  bit          mZero = 1'b1;
  logic [31:0] mNextPc = RESET_PC;
  bit          mIfValid = 1'b0;
  bit          mIfKilled = 1'b0;
  logic [31:0] mIfAddr = 32'd0;
  fetch_t      mBuf[$];

  // Scoreboard queues.
  logic [31:0] reqQ[$];
  fetch_t      xferQ[$];
  cyc_t        cycQ[$];

  inst_fetch_req #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_pc       (fs_to_ds_pc),
    .fs_to_ds_inst     (fs_to_ds_inst),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Contents of the instruction memory as seen through the bridge.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == RESET_PC) return 32'h02800C21;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Runs one cycle of stimulus. The task:
  //   1. records what the DUT should show now;
  //   2. drives the inputs for the next edge;
  //   3. advances the reference model across that edge.
  // --------------------------------------------------------------------------
  task automatic applyStimulus(input bit rstn, input bit rv, input logic [31:0] rpc,
                               input bit allow, input bit aok, input bit dok);
    cyc_t   e;
    fetch_t f;
    bit     curReq;
    bit     curValid;
    @(negedge clk);
    curReq   = !mRstPending && !mIfValid && (mBuf.size() == 0);
    curValid = (mBuf.size() > 0);
    e.req   = curReq;
    e.addr  = mNextPc;
    e.valid = curValid;
    e.pc    = 32'd0;
    e.inst  = 32'd0;
    if (curValid) begin
      e.pc   = mBuf[0].pc;
      e.inst = mBuf[0].inst;
    end
    e.zero = mZero;
    cycQ.push_back(e);

    resetn            = rstn;
    redirect_valid    = rv;
    redirect_pc       = rpc;
    ds_allowin        = allow;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    if (dok && mIfValid)
      inst_sram_rdata = (mIfKilled || rv) ? 32'hDEADBEEF : memWord(mIfAddr);
    else
      inst_sram_rdata = $urandom;

    mZero = 1'b0;
    if (!rstn) begin
      mRstPending = 1'b1;
      mZero       = 1'b1;
      mNextPc     = RESET_PC;
      mIfValid    = 1'b0;
      mIfKilled   = 1'b0;
      mBuf.delete();
    end else if (mRstPending) begin
      mRstPending = 1'b0;
    end else begin
      if (dok && mIfValid) begin
        if (!mIfKilled && !rv) begin
          f.pc   = mIfAddr;
          f.inst = memWord(mIfAddr);
          mBuf.push_back(f);
        end
        mIfValid = 1'b0;
      end
      if (curReq && aok) begin
        reqQ.push_back(mNextPc);
        mIfValid  = 1'b1;
        mIfKilled = rv;
        mIfAddr   = mNextPc;
      end
      if (curValid && allow && !rv) begin
        f = mBuf.pop_front();
        xferQ.push_back(f);
        mNextPc = f.pc + 32'd4;
      end
      if (rv) begin
        mNextPc = rpc;
        if (mIfValid) mIfKilled = 1'b1;
        mBuf.delete();
      end
    end
  endtask

  // Advance until the model says the next cycle is a request cycle.
  task automatic stepUntilIdle(input int maxCycles);
    int n = 0;
    while (!(!mRstPending && !mIfValid && mBuf.size() == 0) && n < maxCycles) begin
      applyStimulus(1, 0, 32'd0, 1, 0, 1);
      n++;
    end
    if (n >= maxCycles) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got=%0d cycles required<%0d", n, maxCycles);
    end
  endtask

  // Advance until a live, uncancelled read is outstanding.
  task automatic stepUntilInflight(input int maxCycles);
    int n = 0;
    while (!(mIfValid && !mIfKilled) && n < maxCycles) begin
      applyStimulus(1, 0, 32'd0, 1, 1, mIfValid);
      n++;
    end
    if (n >= maxCycles) begin
      total++;
      bad++;
      $display("[TB] FAIL inflight_timeout: got=%0d cycles required<%0d", n, maxCycles);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor.
  // It samples 1 time unit after each negedge, once inputs have settled and
  // before the next posedge.
  // --------------------------------------------------------------------------
  initial begin : monitor
    cyc_t   e;
    fetch_t f;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (cycQ.size() != 0) begin
        e = cycQ.pop_front();
        checkOutput("req", inst_sram_req, e.req);
        checkOutput("valid", fs_to_ds_valid, e.valid);
        checkOutput("consts", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                    {1'b0, 2'b10, 4'b0000, 32'd0});
        if (e.req) checkOutput("addr", inst_sram_addr, e.addr);
        if (e.valid) begin
          checkOutput("hold_pc", fs_to_ds_pc, e.pc);
          checkOutput("hold_inst", fs_to_ds_inst, e.inst);
        end
        if (e.zero) begin
          checkOutput("rst_pc", fs_to_ds_pc, 32'd0);
          checkOutput("rst_inst", fs_to_ds_inst, 32'd0);
        end
        if (resetn && inst_sram_req && inst_sram_addr_ok) begin
          checkOutput("req_expected", reqQ.size(), 1);
          if (reqQ.size() != 0) begin
            a = reqQ.pop_front();
            checkOutput("req_addr", inst_sram_addr, a);
          end
        end
        if (resetn && fs_to_ds_valid && ds_allowin && !redirect_valid) begin
          checkOutput("xfer_expected", xferQ.size(), 1);
          if (xferQ.size() != 0) begin
            f = xferQ.pop_front();
            xferSeen++;
            checkOutput("xfer_pc", fs_to_ds_pc, f.pc);
            checkOutput("xfer_inst", fs_to_ds_inst, f.inst);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus sequence.
  // The directed scenarios come first, followed by a randomized stretch.
  // --------------------------------------------------------------------------
  initial begin : driver
    bit          rRst;
    bit          rRv;
    bit          rAllow;
    bit          rAok;
    bit          rDok;
    logic [31:0] rPc;

    // Reset, then back-to-back fetches with a same-cycle bridge.
    repeat (3) applyStimulus(0, 0, 32'd0, 1, 0, 0);
    repeat (9) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Decode backpressure while an instruction is held.
    stepUntilInflight(20);
    repeat (7) applyStimulus(1, 0, 32'd0, 0, 1, 1);
    repeat (4) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // addr_ok withheld, with a redirect arriving before acceptance.
    stepUntilIdle(20);
    applyStimulus(1, 0, 32'd0, 1, 0, 1);
    applyStimulus(1, 1, 32'h1C00_0100, 1, 0, 1);
    applyStimulus(1, 0, 32'd0, 1, 0, 1);
    applyStimulus(1, 0, 32'd0, 1, 0, 1);
    repeat (4) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Redirect while waiting, with the stale data returning 3 cycles later.
    stepUntilInflight(20);
    applyStimulus(1, 1, 32'h1C00_0200, 1, 0, 0);
    repeat (2) applyStimulus(1, 0, 32'd0, 1, 0, 0);
    applyStimulus(1, 0, 32'd0, 1, 0, 1);
    repeat (6) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Redirect together with live data_ok.
    stepUntilInflight(20);
    applyStimulus(1, 1, 32'h1C00_0300, 1, 0, 1);
    repeat (6) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Redirect together with addr_ok.
    stepUntilIdle(20);
    applyStimulus(1, 1, 32'h1C00_0400, 1, 1, 0);
    applyStimulus(1, 0, 32'd0, 1, 0, 1);
    repeat (6) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Redirect in HOLD while decode is ready: the redirect wins.
    stepUntilInflight(20);
    applyStimulus(1, 0, 32'd0, 0, 0, 1);
    applyStimulus(1, 1, 32'h1C00_0500, 1, 0, 0);
    repeat (6) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Address wrap.
    stepUntilIdle(20);
    applyStimulus(1, 1, 32'hFFFF_FFFC, 1, 0, 1);
    repeat (8) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Reset while a read is outstanding.
    stepUntilInflight(20);
    applyStimulus(0, 0, 32'd0, 1, 0, 0);
    repeat (8) applyStimulus(1, 0, 32'd0, 1, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rRst   = ($urandom_range(999) >= 4);
      rRv    = ($urandom_range(99) < 6);
      rAllow = ($urandom_range(99) < 70);
      rAok   = ($urandom_range(99) < 60);
      rDok   = ($urandom_range(99) < 50);
      case ($urandom_range(3))
        0: rPc = $urandom;
        1: rPc = 32'hFFFF_FFF8 + {28'd0, $urandom_range(1) == 1, 2'b00};
        default: rPc = RESET_PC + {18'd0, 12'($urandom), 2'($urandom)};
      endcase
      applyStimulus(rRst, rRv, rPc, rAllow, rAok, rDok);
    end

    applyStimulus(1, 0, 32'd0, 0, 0, 0);
    @(negedge clk);
    #2;
    checkOutput("reqQ_drained", reqQ.size(), 0);
    checkOutput("xferQ_drained", xferQ.size(), 0);
    checkOutput("progress", (xferSeen >= 100), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
